mem_array_arbiter: RTL and testbench

- Shares one 16x16 single-bit memory array (row/column addressed, one registered read port, one write port) among NUM_REQ requesters.
- Round-robin arbitration; one access in flight at a time.
- Sequences each access as accept -> issue -> respond.
- Sits between requester logic and the array instance; owns every array control input.

---
 rtl/mem_array_arbiter_pkg.sv | 15 +
 rtl/mem_array_arbiter_if.sv | 27 ++
 rtl/mem_array_arbiter_rr_priority_pick.sv | 34 +++
 rtl/mem_array_arbiter.sv | 106 ++++++++++
 tb/tb_mem_array_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_array_arbiter_pkg.sv
// Shared definitions for the memory-array arbiter: FSM encoding and array geometry.
package mem_array_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int DEF_ROW_W  = 4;
  localparam int DEF_COL_W  = 4;
  localparam int ARRAY_ROWS = 1 << DEF_ROW_W;
  localparam int ARRAY_COLS = 1 << DEF_COL_W;

endpackage

// File: rtl/mem_array_arbiter_if.sv
// Requester-side bundle: per-requester request fields plus the shared response.
interface mem_array_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ*COL_W-1:0] req_column;
  logic [NUM_REQ-1:0]       req_wdata;
  logic [NUM_REQ-1:0]       resp_valid;
  logic                     resp_rdata;

  modport master (
    output req_valid, req_write, req_row, req_column, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_row, req_column, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_array_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping modulo N.
module mem_array_arbiter_rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  int idx;

  // The pointer is kept below N by its owner, so one subtraction suffices for the wrap.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_valid && valid[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_array_arbiter.sv
// Round-robin arbiter sharing one row/column bit array; accept -> issue -> respond per access.
module mem_array_arbiter
  import mem_array_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int COL_W   = DEF_COL_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  mem_array_arbiter_if.slave  req_bus,
  output logic [ROW_W-1:0]    mem_row,
  output logic [COL_W-1:0]    mem_column,
  output logic                mem_we,
  output logic                mem_wdata,
  input  logic                mem_value,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;
  logic               any_valid;
  logic               accept_open;
  logic               handshake;

  logic               op_write;
  logic [ROW_W-1:0]   op_row;
  logic [COL_W-1:0]   op_column;
  logic               op_wdata;
  logic [ID_W-1:0]    op_id;
  logic [NUM_REQ-1:0] resp_valid_q;

  mem_array_arbiter_rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_priority_pick (
    .valid     (req_bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (win_onehot),
    .winner    (win_id),
    .any_valid (any_valid)
  );

  assign accept_open = (state == IDLE) || (state == RESP);
  assign handshake   = accept_open && any_valid;
  assign rr_next     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  // Ready is forced low while reset is held so no requester sees a phantom accept.
  assign req_bus.req_ready  = (accept_open && reset) ? win_onehot : '0;
  assign req_bus.resp_valid = resp_valid_q;
  assign req_bus.resp_rdata = (state == RESP) ? (op_write ? op_wdata : mem_value) : 1'b0;

  assign mem_row    = op_row;
  assign mem_column = op_column;
  assign mem_wdata  = op_wdata;
  assign busy       = (state != IDLE);

  // FSM with operation registers; mem_we and resp_valid are one-cycle registered pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op_write     <= 1'b0;
      op_row       <= '0;
      op_column    <= '0;
      op_wdata     <= 1'b0;
      op_id        <= '0;
      grant_id     <= '0;
      mem_we       <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      mem_we       <= 1'b0;
      resp_valid_q <= '0;
      case (state)
        IDLE, RESP: begin
          if (handshake) begin
            op_write  <= req_bus.req_write[win_id];
            op_row    <= req_bus.req_row[win_id*ROW_W +: ROW_W];
            op_column <= req_bus.req_column[win_id*COL_W +: COL_W];
            op_wdata  <= req_bus.req_wdata[win_id];
            op_id     <= win_id;
            grant_id  <= win_id;
            rr_ptr    <= rr_next;
            mem_we    <= req_bus.req_write[win_id];
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          resp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << op_id;
          state        <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_array_arbiter.sv
// Directed bench for mem_array_arbiter with a registered-read 16x16 bit array model.
module tb_mem_array_arbiter;
  import mem_array_arbiter_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] mem_row;
  logic [3:0] mem_column;
  logic       mem_we;
  logic       mem_wdata;
  logic       mem_value;
  logic       busy;
  logic [1:0] grant_id;

  int total;
  int bad;
  int order [5] = '{0, 1, 2, 3, 0};

  logic mem_array [ARRAY_ROWS][ARRAY_COLS];

  mem_array_arbiter_if #(.NUM_REQ(4), .ROW_W(4), .COL_W(4)) bus ();

  mem_array_arbiter #(
    .NUM_REQ (4),
    .ROW_W   (4),
    .COL_W   (4),
    .ID_W    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_bus    (bus),
    .mem_row    (mem_row),
    .mem_column (mem_column),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_value  (mem_value),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array model: write on we, read data registered one cycle after the address.
  always @(posedge clock) begin
    if (mem_we) begin
      mem_array[mem_row][mem_column] <= mem_wdata;
    end
    mem_value <= mem_array[mem_row][mem_column];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic wr, input logic [3:0] row,
                               input logic [3:0] col, input logic wd);
    bus.req_valid[i]          = 1'b1;
    bus.req_write[i]          = wr;
    bus.req_row[i*4 +: 4]     = row;
    bus.req_column[i*4 +: 4]  = col;
    bus.req_wdata[i]          = wd;
  endtask

  task automatic releaseRequest(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int r = 0; r < ARRAY_ROWS; r++) begin
      for (int c = 0; c < ARRAY_COLS; c++) begin
        mem_array[r][c] = 1'b0;
      end
    end
    mem_array[1][5] = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_row    = '0;
    bus.req_column = '0;
    bus.req_wdata  = '0;
    reset = 1'b0;

    // Reset state
    nextCycle();
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_grant", 32'(grant_id), 0);
    checkOutput("rst_resp", 32'(bus.resp_valid), 0);
    checkOutput("rst_we", 32'(mem_we), 0);
    checkOutput("rst_row", 32'(mem_row), 0);
    reset = 1'b1;
    nextCycle();

    // Single read of (1,5) by requester 0
    $display("[TB] single read");
    applyStimulus(0, 1'b0, 4'd1, 4'd5, 1'b0);
    #1;
    checkOutput("rd_ready", 32'(bus.req_ready), 32'b0001);
    checkOutput("rd_idle_busy", 32'(busy), 0);
    nextCycle();
    releaseRequest(0);
    #1;
    checkOutput("rd_row", 32'(mem_row), 1);
    checkOutput("rd_col", 32'(mem_column), 5);
    checkOutput("rd_we", 32'(mem_we), 0);
    checkOutput("rd_issue_ready", 32'(bus.req_ready), 0);
    checkOutput("rd_busy", 32'(busy), 1);
    nextCycle();
    #1;
    checkOutput("rd_resp", 32'(bus.resp_valid), 32'b0001);
    checkOutput("rd_rdata", 32'(bus.resp_rdata), 1);
    nextCycle();
    #1;
    checkOutput("rd_done_busy", 32'(busy), 0);
    checkOutput("rd_done_resp", 32'(bus.resp_valid), 0);

    // Write 1 to (3,7) by requester 2, then read it back by requester 1
    $display("[TB] write then read");
    applyStimulus(2, 1'b1, 4'd3, 4'd7, 1'b1);
    #1;
    checkOutput("wr_ready", 32'(bus.req_ready), 32'b0100);
    nextCycle();
    releaseRequest(2);
    #1;
    checkOutput("wr_we", 32'(mem_we), 1);
    checkOutput("wr_row", 32'(mem_row), 3);
    checkOutput("wr_col", 32'(mem_column), 7);
    checkOutput("wr_wdata", 32'(mem_wdata), 1);
    checkOutput("wr_grant", 32'(grant_id), 2);
    nextCycle();
    applyStimulus(1, 1'b0, 4'd3, 4'd7, 1'b0);
    #1;
    checkOutput("wr_resp", 32'(bus.resp_valid), 32'b0100);
    checkOutput("wr_rdata", 32'(bus.resp_rdata), 1);
    checkOutput("wr_resp_we", 32'(mem_we), 0);
    checkOutput("rb_ready", 32'(bus.req_ready), 32'b0010);
    nextCycle();
    releaseRequest(1);
    #1;
    checkOutput("rb_we", 32'(mem_we), 0);
    checkOutput("rb_grant", 32'(grant_id), 1);
    nextCycle();
    #1;
    checkOutput("rb_resp", 32'(bus.resp_valid), 32'b0010);
    checkOutput("rb_rdata", 32'(bus.resp_rdata), 1);
    nextCycle();

    // Contention: all four valid from a fresh reset
    $display("[TB] contention");
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 1'b0, 4'(i), 4'd5, 1'b0);
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("ct_ready", 32'(bus.req_ready), 32'(1) << order[k]);
      nextCycle();
      #1;
      checkOutput("ct_grant", 32'(grant_id), 32'(order[k]));
      checkOutput("ct_issue_ready", 32'(bus.req_ready), 0);
      nextCycle();
      #1;
      checkOutput("ct_resp", 32'(bus.resp_valid), 32'(1) << order[k]);
      checkOutput("ct_rdata", 32'(bus.resp_rdata), (order[k] == 1) ? 1 : 0);
    end
    nextCycle();
    bus.req_valid = '0;
    #1;
    checkOutput("ct_last_grant", 32'(grant_id), 1);
    nextCycle();
    #1;
    checkOutput("ct_last_resp", 32'(bus.resp_valid), 32'b0010);
    nextCycle();
    #1;
    checkOutput("ct_idle", 32'(busy), 0);

    // Pointer wrap: pointer sits at 2
    $display("[TB] pointer wrap");
    applyStimulus(3, 1'b0, 4'd3, 4'd5, 1'b0);
    #1;
    checkOutput("wp_ready3", 32'(bus.req_ready), 32'b1000);
    nextCycle();
    applyStimulus(0, 1'b0, 4'd0, 4'd5, 1'b0);
    applyStimulus(3, 1'b0, 4'd2, 4'd5, 1'b0);
    #1;
    checkOutput("wp_grant3", 32'(grant_id), 3);
    checkOutput("wp_issue_ready", 32'(bus.req_ready), 0);
    nextCycle();
    #1;
    checkOutput("wp_ready0", 32'(bus.req_ready), 32'b0001);
    checkOutput("wp_resp3", 32'(bus.resp_valid), 32'b1000);
    nextCycle();
    releaseRequest(0);
    #1;
    checkOutput("wp_grant0", 32'(grant_id), 0);
    nextCycle();
    #1;
    checkOutput("wp_ready3b", 32'(bus.req_ready), 32'b1000);
    checkOutput("wp_resp0", 32'(bus.resp_valid), 32'b0001);
    nextCycle();
    releaseRequest(3);
    #1;
    checkOutput("wp_grant3b", 32'(grant_id), 3);
    nextCycle();
    #1;
    checkOutput("wp_resp3b", 32'(bus.resp_valid), 32'b1000);
    nextCycle();

    // Idle gaps: one write every 5 cycles, pointer sits at 0
    $display("[TB] idle gaps");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 1'b1, 4'(8 + k), 4'(k), ~1'(k));
      #1;
      checkOutput("gap_ready", 32'(bus.req_ready), 32'(1) << k);
      checkOutput("gap_busy0", 32'(busy), 0);
      checkOutput("gap_we0", 32'(mem_we), 0);
      nextCycle();
      releaseRequest(k);
      #1;
      checkOutput("gap_busy1", 32'(busy), 1);
      checkOutput("gap_we1", 32'(mem_we), 1);
      checkOutput("gap_row", 32'(mem_row), 32'(8 + k));
      nextCycle();
      #1;
      checkOutput("gap_busy2", 32'(busy), 1);
      checkOutput("gap_we2", 32'(mem_we), 0);
      checkOutput("gap_resp", 32'(bus.resp_valid), 32'(1) << k);
      checkOutput("gap_rdata", 32'(bus.resp_rdata), (k == 1) ? 0 : 1);
      nextCycle();
      #1;
      checkOutput("gap_busy3", 32'(busy), 0);
      checkOutput("gap_we3", 32'(mem_we), 0);
      nextCycle();
      #1;
      checkOutput("gap_busy4", 32'(busy), 0);
      nextCycle();
    end

    // Reset during ISSUE of a read by requester 1 (pointer sits at 3)
    $display("[TB] reset mid-operation");
    applyStimulus(1, 1'b0, 4'd1, 4'd5, 1'b0);
    #1;
    checkOutput("mr_ready", 32'(bus.req_ready), 32'b0010);
    nextCycle();
    releaseRequest(1);
    #1;
    checkOutput("mr_issue_row", 32'(mem_row), 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mr_busy", 32'(busy), 0);
    checkOutput("mr_grant", 32'(grant_id), 0);
    checkOutput("mr_row", 32'(mem_row), 0);
    checkOutput("mr_col", 32'(mem_column), 0);
    checkOutput("mr_we", 32'(mem_we), 0);
    checkOutput("mr_wdata", 32'(mem_wdata), 0);
    checkOutput("mr_rdata", 32'(bus.resp_rdata), 0);
    checkOutput("mr_ready0", 32'(bus.req_ready), 0);
    nextCycle();
    #1;
    checkOutput("mr_no_resp", 32'(bus.resp_valid), 0);
    reset = 1'b1;
    nextCycle();
    applyStimulus(0, 1'b0, 4'd1, 4'd5, 1'b0);
    applyStimulus(2, 1'b0, 4'd0, 4'd0, 1'b0);
    #1;
    checkOutput("mr_ptr_ready", 32'(bus.req_ready), 32'b0001);
    nextCycle();
    bus.req_valid = '0;
    #1;
    checkOutput("mr_new_grant", 32'(grant_id), 0);
    nextCycle();
    #1;
    checkOutput("mr_new_resp", 32'(bus.resp_valid), 32'b0001);
    checkOutput("mr_new_rdata", 32'(bus.resp_rdata), 1);
    nextCycle();
    #1;
    checkOutput("mr_final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
